dmem_responder: RTL and testbench

- Data-memory responder on the memory side of the single-cycle CPU's load/store interface.
- Stores are synchronous and loads are combinational, so any load completes in the same cycle.
- Store width and load width/sign come from funct3.
- Also decodes a small MMIO window:
  - console TX FIFO with a valid/ready byte output,
  - status register,
  - free-running cycle counter.

---
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the single-cycle CPU load/store port.
// Byte-addressable RAM with combinational loads, plus console TX FIFO, status and cycle counter MMIO.
`default_nettype none

module dmem_responder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] mem_wr_addr,
    input  logic [WIDTH-1:0] mem_wr_data,
    output logic [WIDTH-1:0] read_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] ADDR_TXDATA = WIDTH'(32'hFFFF_0000);
    localparam logic [WIDTH-1:0] ADDR_STATUS = WIDTH'(32'hFFFF_0004);
    localparam logic [WIDTH-1:0] ADDR_CYCLE  = WIDTH'(32'hFFFF_0008);

    // Storage and state
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          mis_q, mis_d;
    logic [31:0]   cyc_q, cyc_d;

    // Address decode
    logic          is_ram, is_tx, is_st, is_cyc;
    logic [AW-1:0] widx;
    logic [1:0]    boff;

    assign is_ram = (mem_wr_addr[WIDTH-1:AW+2] == '0);
    assign is_tx  = (mem_wr_addr == ADDR_TXDATA);
    assign is_st  = (mem_wr_addr == ADDR_STATUS);
    assign is_cyc = (mem_wr_addr == ADDR_CYCLE);
    assign widx   = mem_wr_addr[AW+1:2];
    assign boff   = mem_wr_addr[1:0];

    // Alignment check and store byte enables
    logic       mis;
    logic       mis_set;
    logic [3:0] be;
    logic       ram_we;
    logic [31:0] wlane;

    always_comb begin
        mis   = 1'b0;
        be    = 4'b0000;
        wlane = mem_wr_data;
        unique case (funct3)
            3'b000: begin
                be    = 4'b0001 << boff;
                wlane = {4{mem_wr_data[7:0]}};
            end
            3'b001: begin
                mis   = boff[0];
                be    = boff[1] ? 4'b1100 : 4'b0011;
                wlane = {2{mem_wr_data[15:0]}};
            end
            3'b010: begin
                mis   = (boff != 2'b00);
                be    = 4'b1111;
            end
            3'b101:  mis = boff[0];
            default: ;
        endcase
    end

    // funct3[2] marks load-only encodings, so it never counts as a misaligned store
    assign mis_set = is_ram & mis & (~mem_write | ~funct3[2]);
    assign ram_we  = mem_write & is_ram & ~mis;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    // Combinational load path
    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ram_rd;

    assign word = mem_q[widx];
    assign bsel = word[{boff, 3'b000} +: 8];
    assign hsel = boff[1] ? word[31:16] : word[15:0];

    always_comb begin
        ram_rd = 32'h0;
        unique case (funct3)
            3'b000:  ram_rd = {{24{bsel[7]}}, bsel};
            3'b100:  ram_rd = {24'h0, bsel};
            3'b001:  ram_rd = boff[0] ? 32'h0 : {{16{hsel[15]}}, hsel};
            3'b101:  ram_rd = boff[0] ? 32'h0 : {16'h0, hsel};
            3'b010:  ram_rd = mis ? 32'h0 : word;
            default: ram_rd = 32'h0;
        endcase
    end

    // TX FIFO control
    logic fifo_empty, fifo_full, pop, push_req, push, ovf_set, st_wr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign pop        = tx_valid & tx_ready;
    assign push_req   = mem_write & is_tx;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign push       = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & fifo_full & ~pop;
    assign st_wr      = mem_write & is_st;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_set | (ovf_q & ~(st_wr & mem_wr_data[2]));
        mis_d = mis_set | (mis_q & ~(st_wr & mem_wr_data[3]));
        cyc_d = (mem_write & is_cyc) ? mem_wr_data : cyc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
            cyc_q    <= 32'h0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mis_q    <= mis_d;
            cyc_q    <= cyc_d;
        end
    end

    // Read mux
    logic [3:0]  cnt4;
    logic [31:0] status_word;

    assign cnt4        = 4'(count_q);
    assign status_word = {24'h0, cnt4, mis_q, ovf_q, fifo_full, fifo_empty};

    always_comb begin
        read_data = '0;
        if (is_ram)      read_data = ram_rd;
        else if (is_st)  read_data = status_word;
        else if (is_cyc) read_data = cyc_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (load results and TX byte stream).
`default_nettype none

module tb_dmem_responder;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC = 32'hFFFF_0008;
    localparam logic [2:0]  F_B   = 3'b000;
    localparam logic [2:0]  F_H   = 3'b001;
    localparam logic [2:0]  F_W   = 3'b010;
    localparam logic [2:0]  F_BU  = 3'b100;
    localparam logic [2:0]  F_HU  = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;
    logic [31:0] rq[$];
    logic [7:0]  txq[$];

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .mem_wr_addr (addr),
        .mem_wr_data (wdata),
        .read_data   (read_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Each op starts at a negedge and ends at the next negedge
    task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] exp);
        mem_write = 1'b0;
        funct3    = f;
        addr      = a;
        wdata     = 32'h0;
        rq.push_back(exp);
        #2;
        check(tag, read_data, rq.pop_front());
        @(negedge clk);
        funct3 = F_W;
        addr   = 32'h0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        mem_write = 1'b1;
        funct3    = f;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        mem_write = 1'b0;
        funct3    = F_W;
        addr      = 32'h0;
        wdata     = 32'h0;
    endtask

    task automatic tx_push(input logic [7:0] b, input bit accepted);
        if (accepted) txq.push_back(b);
        st(A_TX, {24'h0, b}, F_B);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && txq.size() != 0; i++) @(negedge clk);
        check(tag, 32'(txq.size()), 32'd0);
    endtask

    // TX monitor: a pop happens at the coming posedge when valid & ready
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (tx_valid && tx_ready) begin
                if (txq.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
                else check("tx_byte", {24'h0, tx_data}, {24'h0, txq.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        mem_write = 1'b0;
        funct3    = F_W;
        addr      = 32'h0;
        wdata     = 32'h0;
        tx_ready  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'd0);
        ld("rst_status", A_ST, F_W, 32'h1);
        ld("rst_cycle", A_CYC, F_W, 32'h0);

        reset = 1'b1;
        repeat (10) @(negedge clk);
        ld("cycle_10", A_CYC, F_W, 32'd10);

        // RAM widths
        st(32'h10, 32'h8000_00F1, F_W);
        ld("lb", 32'h10, F_B, 32'hFFFF_FFF1);
        ld("lbu", 32'h10, F_BU, 32'h0000_00F1);
        ld("lh", 32'h12, F_H, 32'hFFFF_8000);
        ld("lhu", 32'h12, F_HU, 32'h0000_8000);
        ld("lw", 32'h10, F_W, 32'h8000_00F1);
        ld("l_f3_011", 32'h10, 3'b011, 32'h0);
        st(32'h13, 32'h0000_005A, F_B);
        ld("lw_after_sb", 32'h10, F_W, 32'h5A00_00F1);
        st(32'h16, 32'h0000_BEEF, F_H);
        ld("lw_after_sh", 32'h14, F_W, 32'hBEEF_0000);

        // Same-cycle store: read returns pre-store data
        st(32'h20, 32'hAAAA_5555, F_W);
        mem_write = 1'b1; funct3 = F_W; addr = 32'h20; wdata = 32'h1122_3344;
        #2;
        check("rd_during_wr", read_data, 32'hAAAA_5555);
        @(negedge clk);
        mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
        ld("rd_after_wr", 32'h20, F_W, 32'h1122_3344);

        // Misalignment and out-of-range
        st(32'h12, 32'hDEAD_BEEF, F_W);
        ld("mis_st_nochg", 32'h10, F_W, 32'h5A00_00F1);
        ld("mis_st_status", A_ST, F_W, 32'h9);
        st(A_ST, 32'h8, F_W);
        ld("mis_clr", A_ST, F_W, 32'h1);
        ld("mis_ld_zero", 32'h11, F_H, 32'h0);
        ld("mis_ld_status", A_ST, F_W, 32'h9);
        st(A_ST, 32'h8, F_W);
        ld("oor_lw", 32'h0000_1000, F_W, 32'h0);
        ld("tx_load", A_TX, F_W, 32'h0);
        ld("status_clean", A_ST, F_W, 32'h1);

        // FIFO fill with the sink stalled
        tx_push(8'h41, 1'b1);
        tx_push(8'h42, 1'b1);
        tx_push(8'h43, 1'b1);
        tx_push(8'h44, 1'b1);
        ld("fifo_full", A_ST, F_W, 32'h42);
        check("tx_head_hold", {24'h0, tx_data}, 32'h41);
        tx_push(8'h45, 1'b0);
        ld("fifo_ovf", A_ST, F_W, 32'h46);
        check("tx_head_hold2", {24'h0, tx_data}, 32'h41);
        st(A_ST, 32'h4, F_W);
        ld("ovf_clr", A_ST, F_W, 32'h42);
        tx_ready = 1'b1;
        drain("drain1");
        check("drained_valid", {31'h0, tx_valid}, 32'd0);
        ld("drained_status", A_ST, F_W, 32'h1);

        // Push and pop on the same edge while full
        tx_ready = 1'b0;
        tx_push(8'h51, 1'b1);
        tx_push(8'h52, 1'b1);
        tx_push(8'h53, 1'b1);
        tx_push(8'h54, 1'b1);
        tx_ready = 1'b1;
        tx_push(8'h55, 1'b1);
        ld("full_pushpop", A_ST, F_W, 32'h42);
        drain("drain2");
        ld("drain2_status", A_ST, F_W, 32'h1);

        // Push while empty with the sink ready
        tx_push(8'h66, 1'b1);
        #2;
        check("empty_push_valid", {31'h0, tx_valid}, 32'd1);
        check("empty_push_data", {24'h0, tx_data}, 32'h66);
        @(negedge clk);
        drain("drain3");

        // Cycle counter wrap
        st(A_CYC, 32'hFFFF_FFFE, F_W);
        ld("cyc_fe", A_CYC, F_W, 32'hFFFF_FFFE);
        ld("cyc_ff", A_CYC, F_W, 32'hFFFF_FFFF);
        ld("cyc_wrap", A_CYC, F_W, 32'h0);

        // Asynchronous reset mid-operation
        tx_ready = 1'b0;
        tx_push(8'h71, 1'b1);
        tx_push(8'h72, 1'b1);
        tx_push(8'h73, 1'b1);
        st(A_CYC, 32'h20, F_W);
        addr = A_CYC;
        #2;
        check("pre_rst_cycle", read_data, 32'h20);
        check("pre_rst_valid", {31'h0, tx_valid}, 32'd1);
        reset = 1'b0;
        txq.delete();
        #1;
        check("async_rst_valid", {31'h0, tx_valid}, 32'd0);
        check("async_rst_cycle", read_data, 32'h0);
        @(negedge clk);
        addr = 32'h0;
        ld("ram_kept", 32'h10, F_W, 32'h5A00_00F1);
        reset = 1'b1;
        ld("post_rst_status", A_ST, F_W, 32'h1);
        ld("post_rst_cycle", A_CYC, F_W, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
